// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Instruction-cache read port between the fetch stage and the icache.
//   master : fetch side  (drives imemREN/imemaddr, receives ihit/imemload)
//   slave  : cache side  (receives imemREN/imemaddr, drives ihit/imemload)
//     imemREN   read enable
//     imemaddr  read address (byte address of the instruction)
//     ihit      imemload holds the requested word this cycle
//     imemload  instruction word returned by the cache
interface fetch_stage_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;

    modport master (
        output imemREN,
        output imemaddr,
        input  ihit,
        input  imemload
    );

    modport slave (
        input  imemREN,
        input  imemaddr,
        output ihit,
        output imemload
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage sitting directly after the program counter.
//   Issues a read for the current PC, waits for an icache hit, loads the
//   returned word into the IF/ID register and pulses pc_next so the PC
//   advances (or loads a redirect target on flush). A one-entry skid buffer
//   catches a hit that arrives while decode is stalled.
//
//   Ports
//     CLK          system clock, rising edge
//     RST          synchronous active-high reset
//     icache       icache read port (master side)
//     i_addr       current PC
//     stall        decode stall; IF/ID holds
//     flush        redirect this edge; squash IF/ID
//     halt         halt seen downstream; stop fetching
//     pc_next      PC update enable (advance or redirect)
//     ifid_instr   IF/ID instruction
//     ifid_npc     IF/ID PC + PC_STEP
//     ifid_valid   IF/ID holds a real instruction (0 = bubble)
//     fetch_count  instructions accepted into IF/ID since reset (wraps)
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    fetch_stage_if.master        icache,
    input  logic [31:0]          i_addr,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 halt,
    output logic                 pc_next,
    output logic [31:0]          ifid_instr,
    output logic [31:0]          ifid_npc,
    output logic                 ifid_valid,
    output logic [31:0]          fetch_count
);

    localparam logic [31:0] PC_INC = 32'(PC_STEP);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state, next_state;

    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_npc;

    // Per-cycle datapath actions decided by the control block below.
    logic        load_mem;
    logic        load_skid;
    logic        capture_skid;
    logic        clear_valid;
    logic        clear_skid;

    logic [31:0] fetch_npc;

    assign fetch_npc       = i_addr + PC_INC;
    assign icache.imemaddr = i_addr;

    // Priority: RST > halt > flush > normal fetch/hold handling.
    always_comb begin
        next_state     = state;
        icache.imemREN = 1'b0;
        pc_next        = 1'b0;
        load_mem       = 1'b0;
        load_skid      = 1'b0;
        capture_skid   = 1'b0;
        clear_valid    = 1'b0;
        clear_skid     = 1'b0;

        if (!RST) begin
            case (state)
                HALTED: begin
                    next_state = HALTED;
                end

                FETCH, HOLD: begin
                    icache.imemREN = (state == FETCH);
                    if (halt) begin
                        next_state  = HALTED;
                        clear_valid = 1'b1;
                    end else if (flush) begin
                        // Redirect: PC loads its target, any hit is dropped.
                        pc_next     = 1'b1;
                        clear_valid = 1'b1;
                        clear_skid  = 1'b1;
                        next_state  = FETCH;
                    end else if (state == FETCH) begin
                        if (icache.ihit) begin
                            pc_next = 1'b1;
                            if (stall) begin
                                capture_skid = 1'b1;
                                next_state   = HOLD;
                            end else begin
                                load_mem = 1'b1;
                            end
                        end else if (!stall) begin
                            clear_valid = 1'b1;
                        end
                    end else begin
                        // HOLD: PC already advanced when the skid was filled.
                        if (!stall) begin
                            load_skid  = skid_valid;
                            clear_skid = 1'b1;
                            next_state = FETCH;
                        end
                    end
                end

                default: begin
                    next_state = FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            skid_valid  <= 1'b0;
            skid_instr  <= '0;
            skid_npc    <= '0;
            ifid_instr  <= '0;
            ifid_npc    <= RESET_PC;
            ifid_valid  <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (capture_skid) begin
                skid_valid <= 1'b1;
                skid_instr <= icache.imemload;
                skid_npc   <= fetch_npc;
            end else if (clear_skid) begin
                skid_valid <= 1'b0;
            end

            if (load_mem) begin
                ifid_instr  <= icache.imemload;
                ifid_npc    <= fetch_npc;
                ifid_valid  <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end else if (load_skid) begin
                ifid_instr  <= skid_instr;
                ifid_npc    <= skid_npc;
                ifid_valid  <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end else if (clear_valid) begin
                ifid_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage: reset, back-to-back hits, stall into the
//   skid buffer, flush with a simultaneous hit, a miss run, PC wrap, and halt
//   followed by reset.
module tb_fetch_stage;

    logic        CLK;
    logic        RST;
    logic [31:0] i_addr;
    logic        stall;
    logic        flush;
    logic        halt;
    logic        pc_next;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_npc;
    logic        ifid_valid;
    logic [31:0] fetch_count;

    int checks;
    int failures;

    fetch_stage_if icache ();

    fetch_stage #(
        .RESET_PC (32'h0000_0000),
        .PC_STEP  (4)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .icache      (icache),
        .i_addr      (i_addr),
        .stall       (stall),
        .flush       (flush),
        .halt        (halt),
        .pc_next     (pc_next),
        .ifid_instr  (ifid_instr),
        .ifid_npc    (ifid_npc),
        .ifid_valid  (ifid_valid),
        .fetch_count (fetch_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] instr, input logic [31:0] npc,
                            input logic valid, input logic [31:0] cnt);
        chk({tag, ".instr"}, ifid_instr, instr);
        chk({tag, ".npc"}, ifid_npc, npc);
        chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, valid});
        chk({tag, ".count"}, fetch_count, cnt);
    endtask

    task automatic chk_comb(input string tag, input logic ren, input logic pcn);
        #1;
        chk({tag, ".imemREN"}, {31'd0, icache.imemREN}, {31'd0, ren});
        chk({tag, ".pc_next"}, {31'd0, pc_next}, {31'd0, pcn});
        chk({tag, ".imemaddr"}, icache.imemaddr, i_addr);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST = 1'b1; i_addr = '0; stall = 1'b0; flush = 1'b0; halt = 1'b0;
        icache.ihit = 1'b0; icache.imemload = '0;

        // Reset
        tick(); tick();
        chk_comb("reset", 1'b0, 1'b0);
        chk_ifid("reset", 32'h0, 32'h0, 1'b0, 32'd0);
        RST = 1'b0;

        // Four back-to-back hits
        i_addr = 32'h0;  icache.imemload = 32'h11; icache.ihit = 1'b1;
        chk_comb("b2b0", 1'b1, 1'b1); tick(); chk_ifid("b2b0", 32'h11, 32'h4, 1'b1, 32'd1);
        i_addr = 32'h4;  icache.imemload = 32'h22;
        chk_comb("b2b1", 1'b1, 1'b1); tick(); chk_ifid("b2b1", 32'h22, 32'h8, 1'b1, 32'd2);
        i_addr = 32'h8;  icache.imemload = 32'h33;
        chk_comb("b2b2", 1'b1, 1'b1); tick(); chk_ifid("b2b2", 32'h33, 32'hC, 1'b1, 32'd3);
        i_addr = 32'hC;  icache.imemload = 32'h44;
        chk_comb("b2b3", 1'b1, 1'b1); tick(); chk_ifid("b2b3", 32'h44, 32'h10, 1'b1, 32'd4);

        // Hit under stall -> skid, stall held three cycles
        i_addr = 32'h20; icache.imemload = 32'hAABBCCDD; stall = 1'b1;
        chk_comb("skid_hit", 1'b1, 1'b1); tick();
        chk_ifid("skid_hit", 32'h44, 32'h10, 1'b1, 32'd4);
        icache.ihit = 1'b0; i_addr = 32'h24;
        chk_comb("hold1", 1'b0, 1'b0); tick();
        chk_ifid("hold1", 32'h44, 32'h10, 1'b1, 32'd4);
        chk_comb("hold2", 1'b0, 1'b0); tick();
        chk_ifid("hold2", 32'h44, 32'h10, 1'b1, 32'd4);
        stall = 1'b0;
        chk_comb("hold_rel", 1'b0, 1'b0); tick();
        chk_ifid("hold_rel", 32'hAABBCCDD, 32'h24, 1'b1, 32'd5);

        // Flush with simultaneous hit and stall
        icache.ihit = 1'b1; icache.imemload = 32'hDEADBEEF; stall = 1'b1; flush = 1'b1;
        chk_comb("flush", 1'b1, 1'b1); tick();
        chk_ifid("flush", 32'hAABBCCDD, 32'h24, 1'b0, 32'd5);
        flush = 1'b0; stall = 1'b0; icache.ihit = 1'b0;
        chk_comb("post_flush", 1'b1, 1'b0); tick();
        chk_ifid("post_flush", 32'hAABBCCDD, 32'h24, 1'b0, 32'd5);

        // Five-cycle miss, then the hit lands
        i_addr = 32'h100;
        for (int i = 0; i < 5; i++) begin
            chk_comb("miss", 1'b1, 1'b0); tick();
            chk_ifid("miss", 32'hAABBCCDD, 32'h24, 1'b0, 32'd5);
        end
        icache.ihit = 1'b1; icache.imemload = 32'h55;
        chk_comb("miss_hit", 1'b1, 1'b1); tick();
        chk_ifid("miss_hit", 32'h55, 32'h104, 1'b1, 32'd6);

        // PC wrap
        i_addr = 32'hFFFFFFFC; icache.imemload = 32'h66;
        chk_comb("wrap", 1'b1, 1'b1); tick();
        chk_ifid("wrap", 32'h66, 32'h0, 1'b1, 32'd7);

        // Enter HOLD, halt, then reset mid-stall
        i_addr = 32'h40; icache.imemload = 32'h77; stall = 1'b1;
        chk_comb("pre_halt", 1'b1, 1'b1); tick();
        chk_ifid("pre_halt", 32'h66, 32'h0, 1'b1, 32'd7);
        icache.ihit = 1'b0; halt = 1'b1;
        chk_comb("halt", 1'b0, 1'b0); tick();
        chk_ifid("halt", 32'h66, 32'h0, 1'b0, 32'd7);
        halt = 1'b0; icache.ihit = 1'b1; flush = 1'b1;
        chk_comb("halted", 1'b0, 1'b0); tick();
        chk_ifid("halted", 32'h66, 32'h0, 1'b0, 32'd7);
        flush = 1'b0; stall = 1'b0;
        chk_comb("halted2", 1'b0, 1'b0); tick();
        chk_ifid("halted2", 32'h66, 32'h0, 1'b0, 32'd7);
        RST = 1'b1; stall = 1'b1;
        chk_comb("rst_mid", 1'b0, 1'b0); tick();
        chk_ifid("rst_mid", 32'h0, 32'h0, 1'b0, 32'd0);
        RST = 1'b0; stall = 1'b0; i_addr = 32'h8; icache.imemload = 32'h88;
        chk_comb("resume", 1'b1, 1'b1); tick();
        chk_ifid("resume", 32'h88, 32'hC, 1'b1, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage directly downstream of the program counter. Takes the current PC (i_addr), issues an instruction read to the icache, and waits on ihit. Loads the returned word into the IF/ID pipeline register, and pulses pc_next back to the PC so it advances or takes a redirect. Contains a one-entry skid buffer so a hit arriving during a decode stall is not lost, and a fetch counter for debug.

Parameters:
RESET_PC, 32'h00000000, value presented on ifid_npc after reset (informational only; the PC owns the real reset address).
PC_STEP, 4, byte increment used to form ifid_npc.

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  synchronous, active-high reset
i_addr  input  32  current PC from program counter
imemREN  output  1  icache read enable
imemaddr  output  32  icache read address
ihit  input  1  icache hit; imemload valid this cycle
imemload  input  32  instruction word from icache
stall  input  1  decode stall; IF/ID must hold
flush  input  1  redirect this edge (branch/jump/jr taken); squash IF/ID
halt  input  1  halt seen downstream; stop fetching
pc_next  output  1  PC update enable (advance or redirect)
ifid_instr  output  32  IF/ID instruction
ifid_npc  output  32  IF/ID PC+PC_STEP
ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble)
fetch_count  output  32  instructions accepted into IF/ID since reset

Behaviour:
- States: FETCH, HOLD, HALTED. All registers update on rising CLK. RST has priority over everything.
- Reset (RST=1 at edge):
  - state=FETCH, skid buffer empty.
  - ifid_instr=0, ifid_npc=RESET_PC, ifid_valid=0, fetch_count=0.
  - Combinational outputs are forced low while RST=1: imemREN=0, pc_next=0.
- imemaddr=i_addr at all times.
- FETCH:
  - imemREN=1.
  - ihit=1, stall=0, flush=0: IF/ID <= {imemload, i_addr+PC_STEP, valid=1}; fetch_count++; pc_next=1. Stay FETCH. Zero-wait hits sustain one instruction per cycle.
  - ihit=1, stall=1, flush=0: skid <= {imemload, i_addr+PC_STEP}; pc_next=1; IF/ID unchanged; go HOLD.
  - ihit=0, stall=0, flush=0: ifid_valid <= 0 (bubble); pc_next=0.
  - ihit=0, stall=1, flush=0: IF/ID unchanged; pc_next=0.
- HOLD:
  - imemREN=0, pc_next=0 (PC already advanced).
  - stall=0: IF/ID <= skid, valid=1; fetch_count++; skid emptied; go FETCH.
  - stall=1: hold everything.
- Flush (any state except HALTED, RST=0):
  - Overrides stall and ihit.
  - ifid_valid <= 0; skid emptied; go FETCH.
  - pc_next=1 so the PC loads its redirect target.
  - A simultaneous hit is discarded and fetch_count is unchanged.
  - ifid_instr and ifid_npc keep their old values (don't-care when invalid).
- halt=1 (RST=0):
  - Takes priority over flush. Go HALTED next edge; ifid_valid <= 0.
  - pc_next=0 in the halt cycle.
  - HALTED: imemREN=0, pc_next=0, IF/ID frozen. Only RST exits.
- Arithmetic:
  - i_addr+PC_STEP is 32-bit modulo; 32'hFFFFFFFC yields 0.
  - fetch_count wraps at 2^32.
- pc_next is combinational from state/ihit/stall/flush/halt. There is no registered delay; the PC samples it at the same edge IF/ID loads.

Test Plan:
- Reset then 4 back-to-back hits, i_addr 0,4,8,12, imemload 0x11..0x44 -> pc_next high 4 cycles; ifid_instr follows 0x11..0x44 one cycle behind; ifid_npc 4..16; fetch_count=4.
- Hit 0xAABBCCDD with stall=1 at i_addr 0x20, stall held 3 cycles -> pc_next exactly one pulse, imemREN low in HOLD; after stall drops, ifid_instr=0xAABBCCDD, ifid_npc=0x24, valid=1.
- flush with ihit=1 and stall=1 in the same cycle -> pc_next=1, ifid_valid=0 next cycle, skid empty, fetch_count unchanged.
- ihit low for 5 cycles (miss) -> imemREN held 1, imemaddr stable, pc_next=0, ifid_valid=0 bubbles; the hit then loads normally.
- i_addr=0xFFFFFFFC hit -> ifid_npc=0x00000000.
- halt during HOLD, then RST asserted mid-stall -> HALTED: imemREN=0, pc_next=0; on RST all outputs return to reset values and fetching resumes from FETCH.
